// File: rtl/pulse_train_gen.sv
// Programmable pulse / pulse-train generator (one-shot, N pulses or free-running).
// Define PULSE_TRAIN_CNT_EN to expose the pulse_cnt output.
module pulse_train_gen #(
   parameter int CNT_W = 8,
   parameter int NUM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] high_cycles,
   input  logic [CNT_W-1:0] low_cycles,
   input  logic [NUM_W-1:0] num_pulses,
   output logic             pulse,
   output logic             busy,
`ifdef PULSE_TRAIN_CNT_EN
   output logic [NUM_W-1:0] pulse_cnt,
`endif
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] high_q;
   logic [CNT_W-1:0] low_q;
   logic [CNT_W-1:0] phase_q;
   logic [CNT_W-1:0] high_d;
   logic [CNT_W-1:0] low_d;
   logic [NUM_W-1:0] num_q;
   logic [NUM_W-1:0] pnum_q;
   logic             pulse_q;
   logic             busy_q;
   logic             done_q;
   logic             pnum_max;
   logic             last_pulse;

   // A zero length is stretched to one cycle so every phase is visible.
   assign high_d     = (high_cycles == '0) ? CNT_W'(1) : high_cycles;
   assign low_d      = (low_cycles == '0) ? CNT_W'(1) : low_cycles;
   assign pnum_max   = &pnum_q;
   assign last_pulse = (num_q != '0) && (pnum_q == num_q);

   // Phase sequencer: phase_q counts cycles already spent in the current phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         high_q  <= '0;
         low_q   <= '0;
         num_q   <= '0;
         phase_q <= '0;
         pnum_q  <= '0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  high_q  <= high_d;
                  low_q   <= low_d;
                  num_q   <= num_pulses;
                  phase_q <= CNT_W'(1);
                  pnum_q  <= NUM_W'(1);
                  state_q <= HIGH;
                  pulse_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            HIGH: begin
               if (stop) begin
                  state_q <= IDLE;
                  pulse_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (phase_q == high_q) begin
                  phase_q <= CNT_W'(1);
                  pulse_q <= 1'b0;
                  if (last_pulse) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= LOW;
                  end
               end else begin
                  phase_q <= phase_q + CNT_W'(1);
               end
            end
            LOW: begin
               if (stop) begin
                  state_q <= IDLE;
                  pulse_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (phase_q == low_q) begin
                  phase_q <= CNT_W'(1);
                  state_q <= HIGH;
                  pulse_q <= 1'b1;
                  if (!pnum_max) begin
                     pnum_q <= pnum_q + NUM_W'(1);
                  end
               end else begin
                  phase_q <= phase_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               pulse_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pulse = pulse_q;
   assign busy  = busy_q;
   assign done  = done_q;

`ifdef PULSE_TRAIN_CNT_EN
   // Pulses started since the last accepted start; held after the train ends.
   assign pulse_cnt = pnum_q;
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen.
// Expected {pulse,busy,done} per cycle is queued at stimulus time.
module tb_pulse_train_gen;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [7:0] high_cycles;
   logic [7:0] low_cycles;
   logic [7:0] num_pulses;
   logic       pulse;
   logic       busy;
   logic       done;
`ifdef PULSE_TRAIN_CNT_EN
   logic [7:0] pulse_cnt;
`endif

   int tests;
   int fails;
   logic [2:0] expq[$];

   pulse_train_gen #(
      .CNT_W(8),
      .NUM_W(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .high_cycles(high_cycles),
      .low_cycles (low_cycles),
      .num_pulses (num_pulses),
      .pulse      (pulse),
      .busy       (busy),
`ifdef PULSE_TRAIN_CNT_EN
      .pulse_cnt  (pulse_cnt),
`endif
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; single-cycle requests drop after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [2:0] obs,
                      input logic [2:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pop one expected cycle and compare with the outputs.
   task automatic pop_chk(input string tag);
      logic [2:0] e;
      if (expq.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s observed=queue_empty expected=entry", tag);
      end else begin
         e = expq.pop_front();
         chk(tag, {pulse, busy, done}, e);
      end
   endtask

   // Queue a finite train (n>0) followed by its done cycle.
   task automatic push_train(input int h, input int l, input int n);
      int he;
      int le;
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      for (int i = 1; i <= n; i++) begin
         for (int j = 0; j < he; j++) expq.push_back(3'b110);
         if (i < n)
            for (int j = 0; j < le; j++) expq.push_back(3'b010);
      end
      expq.push_back(3'b001);
   endtask

   task automatic run(input string tag, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         cyc();
         pop_chk(tag);
      end
   endtask

   task automatic setcfg(input int h, input int l, input int n);
      high_cycles = 8'(h);
      low_cycles  = 8'(l);
      num_pulses  = 8'(n);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      start = 1'b1;
      stop  = 1'b0;
      setcfg(3, 2, 1);

      // 1: reset held with start high
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("reset", {pulse, busy, done}, 3'b000);
      end
      start = 1'b0;
      rst_n = 1'b1;
      cyc();
      chk("idle_after_reset", {pulse, busy, done}, 3'b000);

      // 2: one-shot H=3 N=1
      setcfg(3, 2, 1);
      start = 1'b1;
      push_train(3, 2, 1);
      run("oneshot", 4);
      expq.push_back(3'b000);
      run("oneshot_idle", 1);

      // 3: train H=2 L=3 N=3, then back-to-back into 4
      setcfg(2, 3, 3);
      start = 1'b1;
      push_train(2, 3, 3);
      run("train", 13);
`ifdef PULSE_TRAIN_CNT_EN
      chk8("train_cnt", pulse_cnt, 8'd3);
`endif

      // 4: zero config, started in the done cycle
      setcfg(0, 0, 2);
      start = 1'b1;
      push_train(0, 0, 2);
      run("zero_cfg", 4);
      expq.push_back(3'b000);
      run("zero_idle", 1);

      // 5: infinite train, ignored restart, then stop mid-HIGH
      setcfg(1, 1, 0);
      start = 1'b1;
      for (int i = 1; i <= 21; i++)
         expq.push_back((i % 2 == 1) ? 3'b110 : 3'b010);
      for (int i = 1; i <= 21; i++) begin
         cyc();
         pop_chk("infinite");
         if (i == 10) begin
            setcfg(5, 5, 1);
            start = 1'b1;
         end
      end
      stop = 1'b1;
      expq.push_back(3'b000);
      expq.push_back(3'b000);
      run("stop", 2);
`ifdef PULSE_TRAIN_CNT_EN
      chk8("stop_cnt", pulse_cnt, 8'd11);
`endif

      // 6: async reset in 2nd HIGH cycle, then a full train
      setcfg(4, 2, 2);
      start = 1'b1;
      expq.push_back(3'b110);
      expq.push_back(3'b110);
      run("pre_reset", 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", {pulse, busy, done}, 3'b000);
      cyc();
      chk("in_reset", {pulse, busy, done}, 3'b000);
`ifdef PULSE_TRAIN_CNT_EN
      chk8("reset_cnt", pulse_cnt, 8'd0);
`endif
      #2;
      rst_n = 1'b1;
      cyc();
      chk("post_reset_idle", {pulse, busy, done}, 3'b000);
      setcfg(4, 2, 2);
      start = 1'b1;
      push_train(4, 2, 2);
      run("after_reset", 11);
      expq.push_back(3'b000);
      run("final_idle", 1);

      tests++;
      assert (expq.size() == 0)
      else begin
         fails++;
         $error("FAIL queue_drain observed=%0d expected=0", expq.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
